system_nios2_mul_sequencer: RTL and testbench

Iterative 32x32->64 multiply controller for the Nios II custom-multiply path. It holds one registered 16x16 unsigned multiplier cell and runs four partial products through it in sequence, accumulating into a 64-bit product. It handles unsigned, signed x unsigned and signed x signed operand modes. It sits between the M-stage operand latch and writeback, with a valid/ready handshake on both sides.

---
 rtl/system_nios2_mul_sequencer.sv | 145 ++++++++++++++
 tb/tb_system_nios2_mul_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/system_nios2_mul_sequencer.sv
// Iterative 32x32->64 multiplier: four 16x16 partial products through one registered cell.
// Define SYSTEM_NIOS2_MUL_SIGNED_EN to build signed operand handling (op[1] selects it).
module system_nios2_mul_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic [1:0]  op,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [63:0] result
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DRAIN, S_SIGN, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [1:0]  cell_k_q, cell_k_d;
  logic [31:0] mag_a_q, mag_a_d;
  logic [31:0] mag_b_q, mag_b_d;
  logic        neg_q, neg_d;
  logic [31:0] cell_q, cell_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] result_q, result_d;
  logic        start_ready_q, start_ready_d;
  logic        result_valid_q, result_valid_d;

  logic [31:0] mag_a_in, mag_b_in;
  logic        neg_in;
  logic [15:0] op_a, op_b;
  logic [63:0] cell_shifted;

`ifdef SYSTEM_NIOS2_MUL_SIGNED_EN
  assign mag_a_in = (op[1] && src1[31]) ? (~src1 + 32'd1) : src1;
  assign mag_b_in = ((op == 2'b11) && src2[31]) ? (~src2 + 32'd1) : src2;
  assign neg_in   = (src1[31] & op[1]) ^ (src2[31] & (op == 2'b11));
`else
  logic unused_op;
  assign unused_op = ^op;
  assign mag_a_in  = src1;
  assign mag_b_in  = src2;
  assign neg_in    = 1'b0;
`endif

  // k[0] picks the high half of A, k[1] the high half of B.
  assign op_a = cnt_q[0] ? mag_a_q[31:16] : mag_a_q[15:0];
  assign op_b = cnt_q[1] ? mag_b_q[31:16] : mag_b_q[15:0];

  always_comb begin
    case (cell_k_q)
      2'd0:    cell_shifted = {32'd0, cell_q};
      2'd3:    cell_shifted = {cell_q, 32'd0};
      default: cell_shifted = {16'd0, cell_q, 16'd0};
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cell_k_d       = cnt_q;
    mag_a_d        = mag_a_q;
    mag_b_d        = mag_b_q;
    neg_d          = neg_q;
    cell_d         = {16'd0, op_a} * {16'd0, op_b};
    acc_d          = acc_q;
    result_d       = result_q;
    start_ready_d  = start_ready_q;
    result_valid_d = result_valid_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid && start_ready_q) begin
          mag_a_d       = mag_a_in;
          mag_b_d       = mag_b_in;
          neg_d         = neg_in;
          cnt_d         = 2'd0;
          acc_d         = 64'd0;
          start_ready_d = 1'b0;
          state_d       = S_MUL;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 2'd1;
        // The cell holds nothing useful until the first pair has been issued.
        if (cnt_q != 2'd0) acc_d = acc_q + cell_shifted;
        if (cnt_q == 2'd3) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        acc_d   = acc_q + cell_shifted;
        state_d = S_SIGN;
      end
      S_SIGN: begin
        result_d       = neg_q ? (~acc_q + 64'd1) : acc_q;
        result_valid_d = 1'b1;
        state_d        = S_DONE;
      end
      S_DONE: begin
        if (result_ready) begin
          result_valid_d = 1'b0;
          start_ready_d  = 1'b1;
          state_d        = S_IDLE;
        end
      end
      default: begin
        result_valid_d = 1'b0;
        start_ready_d  = 1'b1;
        state_d        = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= 2'd0;
      cell_k_q       <= 2'd0;
      mag_a_q        <= 32'd0;
      mag_b_q        <= 32'd0;
      neg_q          <= 1'b0;
      cell_q         <= 32'd0;
      acc_q          <= 64'd0;
      result_q       <= 64'd0;
      start_ready_q  <= 1'b1;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cell_k_q       <= cell_k_d;
      mag_a_q        <= mag_a_d;
      mag_b_q        <= mag_b_d;
      neg_q          <= neg_d;
      cell_q         <= cell_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      start_ready_q  <= start_ready_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign start_ready  = start_ready_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;

endmodule

// File: tb/tb_system_nios2_mul_sequencer.sv
// Self-checking bench for system_nios2_mul_sequencer: vector table, corner sequences, random regression.
module tb_system_nios2_mul_sequencer;

`ifdef SYSTEM_NIOS2_MUL_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [1:0]  op;
  logic        result_valid;
  logic        result_ready;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  system_nios2_mul_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .src1         (src1),
    .src2         (src2),
    .op           (op),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  o;
    logic [63:0] exp_sgn;
    logic [63:0] exp_uns;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference product straight from the operand-mode definitions.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    logic signed [63:0] sa, sb;
    if (SIGNED_EN && o[1]) begin
      sa = $signed({{32{a[31]}}, a});
      sb = o[0] ? $signed({{32{b[31]}}, b}) : $signed({32'd0, b});
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Issues one operation, checks latency, stall stability and the handshake.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] o, input logic [63:0] exp, input int stall, input bit pulse);
    int          lat;
    int          w;
    logic [63:0] held;
    w = 0;
    while (!start_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " ready_wait"}, 64'(start_ready), 64'd1);
    start_valid = 1'b1;
    src1 = a;
    src2 = b;
    op = o;
    @(negedge clk);
    start_valid = 1'b0;
    src1 = $urandom();
    src2 = $urandom();
    op = 2'($urandom_range(0, 3));
    lat = 1;
    while (!result_valid && lat < 20) begin
      if (start_ready) begin
        bad++;
        total++;
        $display("FAIL %s busy_start_ready: got 1 want 0 at cycle %0d", nm, lat);
      end
      if (pulse && lat == 2) begin
        start_valid = 1'b1;
        src1 = 32'd7;
        src2 = 32'd7;
      end else begin
        start_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start_valid = 1'b0;
    chk({nm, " latency"}, 64'(lat), 64'd7);
    chk({nm, " result"}, result, exp);
    chk({nm, " no_overlap"}, 64'(start_ready), 64'd0);
    held = result;
    for (int s = 0; s < stall; s++) begin
      result_ready = 1'b0;
      @(negedge clk);
      chk({nm, " stall_valid"}, 64'(result_valid), 64'd1);
      chk({nm, " stall_result"}, result, held);
      chk({nm, " stall_start_ready"}, 64'(start_ready), 64'd0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk({nm, " post_valid"}, 64'(result_valid), 64'd0);
    chk({nm, " post_start_ready"}, 64'(start_ready), 64'd1);
    $display("op %s a=%h b=%h op=%b result=%h exp=%h lat=%0d stall=%0d", nm, a, b, o, held, exp, lat, stall);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    logic [63:0] e;

    vecs[0] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 64'hFFFFFFFE_00000001, 64'hFFFFFFFE_00000001};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 64'h00000000_00000001, 64'hFFFFFFFE_00000001};
    vecs[2] = '{32'h80000000, 32'h80000000, 2'b11, 64'h40000000_00000000, 64'h40000000_00000000};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 64'hFFFFFFFF_00000001, 64'hFFFFFFFE_00000001};
    vecs[4] = '{32'd3,        32'd5,        2'b00, 64'd15,                64'd15};
    vecs[5] = '{32'h00010000, 32'h00010000, 2'b00, 64'h00000001_00000000, 64'h00000001_00000000};
    vecs[6] = '{32'h00000000, 32'h12345678, 2'b11, 64'd0,                 64'd0};
    vecs[7] = '{32'hFFFFFFFE, 32'd3,        2'b11, 64'hFFFFFFFF_FFFFFFFA, 64'h00000002_FFFFFFFA};
    vecs[8] = '{32'h00010001, 32'h00010001, 2'b10, 64'h00000001_00020001, 64'h00000001_00020001};
    vecs[9] = '{32'h7FFFFFFF, 32'h80000000, 2'b11, 64'hC0000000_80000000, 64'h3FFFFFFF_80000000};

    reset = 1'b1;
    start_valid = 1'b0;
    result_ready = 1'b0;
    src1 = '0;
    src2 = '0;
    op = '0;
    repeat (3) @(negedge clk);
    chk("reset start_ready", 64'(start_ready), 64'd1);
    chk("reset result_valid", 64'(result_valid), 64'd0);
    chk("reset result", result, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle start_ready", 64'(start_ready), 64'd1);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].o,
             SIGNED_EN ? vecs[i].exp_sgn : vecs[i].exp_uns, i % 2, 1'b0);

    // Backpressure with an ignored start pulse, then a normal follow-on op.
    run_op("backpressure", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 64'hFFFFFFFE_00000001, 5, 1'b1);
    run_op("after_bp", 32'd3, 32'd5, 2'b00, 64'd15, 0, 1'b0);

    // Reset while the cell is processing k=2.
    start_valid = 1'b1;
    src1 = 32'hDEADBEEF;
    src2 = 32'h12345678;
    op = 2'b00;
    @(negedge clk);
    start_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset start_ready", 64'(start_ready), 64'd1);
    chk("midreset result_valid", 64'(result_valid), 64'd0);
    chk("midreset result", result, 64'd0);
    $display("op midreset start_ready=%b result_valid=%b result=%h", start_ready, result_valid, result);
    run_op("fresh", 32'h00010000, 32'h00010000, 2'b00, 64'h00000001_00000000, 0, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 7))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        default: ra = $urandom();
      endcase
      case ($urandom_range(0, 7))
        0: rb = 32'h80000000;
        1: rb = 32'h7FFFFFFF;
        default: rb = $urandom();
      endcase
      ro = 2'($urandom_range(0, 3));
      e = ref_mul(ra, rb, ro);
      run_op($sformatf("rnd%0d", n), ra, rb, ro, e,
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
